// File: rtl/psum_writeback_if.sv
// Purpose : handshake and write-bus bundle for psum_writeback.
//   lanes_data_i / lanes_valid_i / lanes_ready_o : psum beat stream into the block
//   mem_wr_en_o / mem_wr_addr_o / mem_wr_data_o / mem_wr_ready_i : memory write port
// Modports: master = environment side (beat source + memory), slave = psum_writeback.
`timescale 1ns/1ps
interface psum_writeback_if #(
  parameter int unsigned NUM_LANES = 3,
  parameter int unsigned PSUM_W    = 20,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ADDR_W    = 16
);
  logic [NUM_LANES*PSUM_W-1:0] lanes_data_i;
  logic                        lanes_valid_i;
  logic                        lanes_ready_o;
  logic                        mem_wr_en_o;
  logic [ADDR_W-1:0]           mem_wr_addr_o;
  logic signed [DATA_W-1:0]    mem_wr_data_o;
  logic                        mem_wr_ready_i;

  modport master (
    output lanes_data_i, lanes_valid_i, mem_wr_ready_i,
    input  lanes_ready_o, mem_wr_en_o, mem_wr_addr_o, mem_wr_data_o
  );

  modport slave (
    input  lanes_data_i, lanes_valid_i, mem_wr_ready_i,
    output lanes_ready_o, mem_wr_en_o, mem_wr_addr_o, mem_wr_data_o
  );
endinterface

// File: rtl/psum_writeback.sv
// Purpose : buffers multi-lane psum beats in a small FIFO and writes them out
//           one lane per memory write, shifted and reduced to DATA_W.
// Ports   : clk, rst (sync, active-high); start_i + cfg_* start a job;
//           busy_o high in RUN/DRAIN; done_o one-cycle completion pulse;
//           bus (psum_writeback_if.slave) carries the beat stream and write port.
// Config  : define PSUM_WB_SATURATE_EN to clamp instead of truncate the
//           shifted psum to DATA_W bits.
`timescale 1ns/1ps
module psum_writeback #(
  parameter int unsigned NUM_LANES  = 3,
  parameter int unsigned PSUM_W     = 20,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] cfg_base_addr,
  input  logic [ADDR_W-1:0] cfg_row_stride,
  input  logic [7:0]        cfg_num_rows,
  input  logic [4:0]        cfg_shift,
  output logic              busy_o,
  output logic              done_o,
  psum_writeback_if.slave   bus
);

  localparam int unsigned BEAT_W = NUM_LANES * PSUM_W;
  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_LANES - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state_q, state_nxt;
  logic [ADDR_W-1:0] row_addr_q;
  logic [ADDR_W-1:0] stride_q;
  logic [7:0]        num_rows_q;
  logic [4:0]        shift_q;
  logic [7:0]        beat_cnt_q;
  logic [LANE_W-1:0] lane_q;
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic [BEAT_W-1:0] fifo_mem [FIFO_DEPTH];

  logic              fifo_empty, fifo_full, active, wr_en;
  logic              push, wr_fire, pop, start_acc;
  logic [PSUM_W-1:0] head_lanes [NUM_LANES];
  logic [PSUM_W-1:0] lane_psum;
  logic [DATA_W-1:0] reduced;

  // Handshake decode
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FULL_CNT);
  assign active     = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign wr_en      = active && !fifo_empty;
  assign push       = bus.lanes_valid_i && bus.lanes_ready_o;
  assign wr_fire    = wr_en && bus.mem_wr_ready_i;
  assign pop        = wr_fire && (lane_q == LAST_LANE);
  assign start_acc  = (state_q == S_IDLE) && start_i;

  // No bypass: ready depends only on registered occupancy
  assign bus.lanes_ready_o = (state_q == S_RUN) && !fifo_full;
  assign bus.mem_wr_en_o   = wr_en;
  // Address/data forced to zero when idle so reset leaves the port quiet
  assign bus.mem_wr_addr_o = wr_en ? (row_addr_q + ADDR_W'(lane_q)) : '0;
  assign bus.mem_wr_data_o = wr_en ? reduced : '0;
  assign busy_o            = active;
  assign done_o            = (state_q == S_DONE);

  // Split FIFO head into lanes and select the lane being written
  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      head_lanes[i] = fifo_mem[rd_ptr_q][i*PSUM_W +: PSUM_W];
    end
    lane_psum = head_lanes[lane_q];
  end

`ifdef PSUM_WB_SATURATE_EN
  localparam logic signed [PSUM_W-1:0] SAT_MAX = PSUM_W'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [PSUM_W-1:0] SAT_MIN = ~SAT_MAX;
  logic signed [PSUM_W-1:0] shifted;

  // Clamp the shifted psum to the signed DATA_W range
  always_comb begin
    shifted = $signed(lane_psum) >>> shift_q;
    if (shifted > SAT_MAX)      reduced = DATA_W'(SAT_MAX);
    else if (shifted < SAT_MIN) reduced = DATA_W'(SAT_MIN);
    else                        reduced = DATA_W'(shifted);
  end
`else
  // Keep the low DATA_W bits of the shifted psum (two's-complement wrap)
  always_comb begin
    reduced = DATA_W'($signed(lane_psum) >>> shift_q);
  end
`endif

  // Next-state logic
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      S_IDLE:  if (start_i) state_nxt = (cfg_num_rows != 8'd0) ? S_RUN : S_DONE;
      S_RUN:   if (push && (beat_cnt_q == num_rows_q - 8'd1)) state_nxt = S_DRAIN;
      S_DRAIN: if (fifo_empty || (pop && (count_q == CNT_W'(1)))) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_nxt;
  end

  // Job config, counters and FIFO pointers
  always_ff @(posedge clk) begin
    if (rst) begin
      row_addr_q <= '0;
      stride_q   <= '0;
      num_rows_q <= '0;
      shift_q    <= '0;
      beat_cnt_q <= '0;
      lane_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      if (start_acc) begin
        row_addr_q <= cfg_base_addr;
        stride_q   <= cfg_row_stride;
        num_rows_q <= cfg_num_rows;
        shift_q    <= cfg_shift;
        beat_cnt_q <= '0;
        lane_q     <= '0;
      end
      if (push) begin
        beat_cnt_q <= beat_cnt_q + 8'd1;
        wr_ptr_q   <= wr_ptr_q + PTR_W'(1);
      end
      if (wr_fire) lane_q <= pop ? '0 : lane_q + LANE_W'(1);
      // Row base advances by one stride per popped beat
      if (pop) begin
        rd_ptr_q   <= rd_ptr_q + PTR_W'(1);
        row_addr_q <= row_addr_q + stride_q;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // FIFO storage; validity is tracked by count_q, so no reset needed
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= bus.lanes_data_i;
  end

endmodule
